// File: rtl/kyber_poly_op_scheduler.sv
// Command sequencer for the Kyber polynomial address generator:
// queued multi-bank ops, inter-bank idle gap, tagged retire, watchdog.
module kyber_poly_op_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023,
  parameter int WD_WIDTH   = 10,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [1:0]                    cmd_npoly,
  input  logic [2:0]                    cmd_base,
  input  logic [3:0]                    cmd_tag,
  output logic [2:0]                    ag_sel,
  input  logic                          ag_done_flag,
  output logic [2:0]                    poly_idx,
  output logic                          busy,
  output logic                          done_valid,
  output logic [3:0]                    done_tag,
  output logic                          err,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_RETIRE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] npoly;
    logic [2:0] base;
    logic [3:0] tag;
  } cmd_t;

  state_t              state;
  cmd_t                mem [FIFO_DEPTH];
  cmd_t                head;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                flush;
  logic [1:0]          op_q;
  logic [1:0]          rem;
  logic [3:0]          tag_q;
  logic [WD_WIDTH-1:0] wd;
  logic [GW-1:0]       gap_cnt;

  assign full       = (count == LW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full && (state != S_ERR);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !empty;
  assign head       = mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !empty;
  assign fifo_level = count;

  // a timeout discards everything still queued behind the failed op
  assign flush = (state == S_WAIT) && !ag_done_flag &&
                 (wd == WD_WIDTH'(TIMEOUT));

  function automatic logic [2:0] sel_code(input logic [1:0] op);
    logic [2:0] s;
    s = 3'b000;
    unique case (op)
      2'b00: s = 3'b001;
      2'b01: s = 3'b100;
      2'b10: s = 3'b010;
      2'b11: s = 3'b110;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, npoly: cmd_npoly,
                       base: cmd_base, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ag_sel     <= 3'b000;
      poly_idx   <= 3'd0;
      done_valid <= 1'b0;
      done_tag   <= 4'd0;
      err        <= 1'b0;
      op_q       <= 2'd0;
      rem        <= 2'd0;
      tag_q      <= 4'd0;
      wd         <= '0;
      gap_cnt    <= '0;
    end else begin
      done_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            op_q     <= head.op;
            rem      <= head.npoly;
            poly_idx <= head.base;
            tag_q    <= head.tag;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          ag_sel <= sel_code(op_q);
          wd     <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ag_done_flag) begin
            ag_sel  <= 3'b000;
            gap_cnt <= '0;
            state   <= (rem != 2'd0) ? S_GAP : S_RETIRE;
          end else if (wd == WD_WIDTH'(TIMEOUT)) begin
            ag_sel <= 3'b000;
            err    <= 1'b1;
            state  <= S_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            poly_idx <= poly_idx + 1'b1;
            rem      <= rem - 1'b1;
            state    <= S_LAUNCH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RETIRE: begin
          done_valid <= 1'b1;
          done_tag   <= tag_q;
          state      <= S_IDLE;
        end
        S_ERR: begin
          ag_sel <= 3'b000;
          if (err_clr) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
